// File: rtl/ukf_mem_pkg.sv
// ukf_mem_pkg: shared memory geometry and transfer states for the UKF matrix reader and result writer.
package ukf_mem_pkg;
  localparam int ELEM_W = 32;
  localparam int LANES = 4;
  localparam int WORD_W = 128;
  localparam int MAX_N = 16;
  localparam int ADDR_W = 10;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/matrix_reader_wordbuf.sv
// matrix_reader_wordbuf: 2-entry 128-bit word FIFO with a lane pointer into the head word.
module matrix_reader_wordbuf
  import ukf_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_pop,
  input  logic              i_adv,
  output logic [WORD_W-1:0] o_head,
  output logic [WORD_W-1:0] o_second,
  output logic [1:0]        o_count,
  output logic [1:0]        o_lane
);
  logic [WORD_W-1:0] r_mem [2];
  logic r_wp, r_rp;
  logic [1:0] r_cnt, r_lane;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= 2'd0;
      r_lane <= 2'd0;
    end else begin
      if (i_push) r_wp <= ~r_wp;
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
      r_lane <= i_pop ? 2'd0 : r_lane + 2'(i_adv);
    end
  end
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end
  assign o_head = r_mem[r_rp];
  assign o_second = r_mem[~r_rp];
  assign o_count = r_cnt;
  assign o_lane = r_lane;
endmodule

// File: rtl/matrix_reader.sv
// matrix_reader: streams an NxN matrix of 32-bit elements from 128-bit memory words with row/col tags.
module matrix_reader #(
  parameter int ADDR_W = ukf_mem_pkg::ADDR_W,
  parameter int MAX_N = ukf_mem_pkg::MAX_N
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [4:0]                      matrix_size,
  input  logic [ADDR_W-1:0]               base_address,
  output logic [ADDR_W-1:0]               address,
  output logic                            read,
  input  logic [ukf_mem_pkg::WORD_W-1:0]  readdata,
  output logic                            chipselect2,
  output logic                            clken2,
  output logic [15:0]                     byteenable,
  output logic                            write,
  output logic [ukf_mem_pkg::ELEM_W-1:0]  out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [3:0]                      out_row,
  output logic [3:0]                      out_col,
  output logic                            out_diag,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);
  import ukf_mem_pkg::*;
  state_t r_state, w_state_nx;
  logic [4:0] r_n, w_n;
  logic [9:0] w_nn;
  logic [8:0] r_nn, r_k, w_k_nx, w_nn_nx;
  logic [6:0] r_words, r_wcnt, w_words;
  logic [ADDR_W-1:0] r_addr;
  logic [ELEM_W-1:0] r_data;
  logic [3:0] r_row, r_col, w_row_nx, w_col_nx;
  logic r_read, r_rvalid, r_valid, r_diag, r_last, r_busy, r_done;
  logic w_idle, w_load, w_hs, w_pop, w_read_nx, w_valid_nx, w_act_nx, w_col_wrap;
  logic [1:0] w_cnt, w_cnt_nx, w_lane, w_lane_nx;
  logic [WORD_W-1:0] w_head, w_second, w_head_nx;

  matrix_reader_wordbuf u_buf (
    .clock(clock), .reset(reset), .i_push(r_rvalid), .i_din(readdata), .i_pop(w_pop),
    .i_adv(w_hs), .o_head(w_head), .o_second(w_second), .o_count(w_cnt), .o_lane(w_lane)
  );

  assign w_n = (matrix_size > 5'(MAX_N)) ? 5'(MAX_N) : matrix_size;
  assign w_nn = 10'(w_n) * 10'(w_n);
  assign w_words = 7'((w_nn + 10'd3) >> 2);
  assign w_idle = r_state == IDLE;
  assign w_load = w_idle && start;
  assign w_nn_nx = w_load ? w_nn[8:0] : r_nn;
  assign w_hs = r_valid && out_ready;
  assign w_pop = w_hs && (w_lane == 2'(LANES - 1) || r_k == r_nn - 9'd1);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    w_state_nx = start ? (w_n == 5'd0 ? DONE : READ) : IDLE;
      READ:    w_state_nx = (r_read && r_wcnt + 7'd1 == r_words) ? DRAIN : READ;
      DRAIN:   w_state_nx = (w_hs && r_last) ? DONE : DRAIN;
      default: w_state_nx = IDLE;
    endcase
  end

  // Credit check looks at next-cycle occupancy so the registered strobe never overfills the buffer.
  assign w_cnt_nx = w_cnt + 2'(r_rvalid) - 2'(w_pop);
  assign w_act_nx = w_state_nx == READ || w_state_nx == DRAIN;
  assign w_read_nx = w_state_nx == READ && 3'(w_cnt_nx) + 3'(r_read) < 3'd2;
  assign w_valid_nx = w_act_nx && w_cnt_nx != 2'd0;
  assign w_head_nx = w_pop ? (w_cnt == 2'd2 ? w_second : readdata) : (w_cnt == 2'd0 ? readdata : w_head);
  assign w_lane_nx = w_pop ? 2'd0 : w_lane + 2'(w_hs);
  assign w_col_wrap = {1'b0, r_col} == r_n - 5'd1;
  assign w_k_nx = w_idle ? 9'd0 : r_k + 9'(w_hs);
  assign w_col_nx = w_idle ? 4'd0 : !w_hs ? r_col : w_col_wrap ? 4'd0 : r_col + 4'd1;
  assign w_row_nx = w_idle ? 4'd0 : (w_hs && w_col_wrap) ? r_row + 4'd1 : r_row;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_n <= 5'd0;
      r_nn <= 9'd0;
      r_words <= 7'd0;
      r_wcnt <= 7'd0;
      r_addr <= '0;
      r_read <= 1'b0;
      r_rvalid <= 1'b0;
      r_k <= 9'd0;
      r_row <= 4'd0;
      r_col <= 4'd0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_diag <= 1'b0;
      r_last <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_n <= w_n;
        r_nn <= w_nn[8:0];
        r_words <= w_words;
      end
      r_wcnt <= w_idle ? 7'd0 : r_wcnt + 7'(r_read);
      r_addr <= w_load ? base_address : r_addr + ADDR_W'(r_read);
      r_read <= w_read_nx;
      r_rvalid <= r_read;
      r_k <= w_k_nx;
      r_row <= w_row_nx;
      r_col <= w_col_nx;
      r_valid <= w_valid_nx;
      if (w_valid_nx) r_data <= w_head_nx[w_lane_nx * ELEM_W +: ELEM_W];
      r_diag <= w_act_nx && w_row_nx == w_col_nx;
      r_last <= w_act_nx && w_k_nx == w_nn_nx - 9'd1;
      r_busy <= w_state_nx != IDLE;
      r_done <= w_state_nx == DONE;
    end
  end

  assign address = r_addr;
  assign read = r_read;
  assign chipselect2 = r_busy;
  assign busy = r_busy;
  assign clken2 = 1'b1;
  assign byteenable = 16'hFFFF;
  assign write = 1'b0;
  assign out_data = r_data;
  assign out_valid = r_valid;
  assign out_row = r_row;
  assign out_col = r_col;
  assign out_diag = r_diag;
  assign out_last = r_last;
  assign done = r_done;
endmodule

// File: tb/tb_matrix_reader.sv
// tb_matrix_reader: directed scenarios for matrix_reader against a 1-cycle-latency memory model.
module tb_matrix_reader;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [4:0] matrix_size = 5'd0;
  logic [9:0] base_address = 10'd0;
  logic [127:0] readdata = '0;
  logic [9:0] address;
  logic read, chipselect2, clken2, write, out_valid, out_diag, out_last, busy, done;
  logic [15:0] byteenable;
  logic [31:0] out_data;
  logic [3:0] out_row, out_col;
  logic [41:0] el;
  logic [127:0] mem [1024];
  int n_cmp = 0, n_fail = 0;
  logic [41:0] g_el[$];
  logic [9:0] g_addr[$];
  int first_valid, done_rel, done_cnt, busy_after, stall_err, max_out;

  matrix_reader dut (
    .clock(clock), .reset(reset), .start(start), .matrix_size(matrix_size),
    .base_address(base_address), .address(address), .read(read), .readdata(readdata),
    .chipselect2(chipselect2), .clken2(clken2), .byteenable(byteenable), .write(write),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_col(out_col), .out_diag(out_diag), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (read) readdata <= mem[address];
  assign el = {out_data, out_row, out_col, out_diag, out_last};

  task automatic fill(input logic [9:0] base, input int words, input logic [31:0] seed);
    for (int j = 0; j < words; j++)
      for (int l = 0; l < 4; l++) mem[base + 10'(j)][l*32 +: 32] = seed + 32'(4*j + l);
  endtask

  function automatic logic [41:0] exp_el(input int k, input int n, input logic [31:0] seed);
    int r, c;
    r = k / n;
    c = k % n;
    return {seed + 32'(k), 4'(r), 4'(c), r == c, k == n*n - 1};
  endfunction

  function automatic int count_bad(input int n, input logic [31:0] seed);
    int b = 0;
    foreach (g_el[k]) if (g_el[k] !== exp_el(k, n, seed)) b++;
    return b;
  endfunction

  // rel 0 is the cycle in which start is high; outputs are sampled on the falling edge.
  task automatic run(input int n, input logic [9:0] base, input bit stall, input int restart_at,
                     input int stop_after, input int budget);
    int hs_n = 0, iss = 0;
    logic [42:0] prev = '0;
    logic prev_hold = 1'b0;
    g_el.delete(); g_addr.delete();
    first_valid = -1; done_rel = -1; done_cnt = 0; busy_after = -1; stall_err = 0; max_out = 0;
    @(posedge clock); #1;
    start = 1'b1; matrix_size = 5'(n); base_address = base; out_ready = 1'b1;
    for (int rel = 0; rel < budget; rel++) begin
      @(negedge clock);
      if (prev_hold && {out_valid, el} !== prev) stall_err++;
      if (read) begin iss++; g_addr.push_back(address); end
      if (iss - hs_n / 4 > max_out) max_out = iss - hs_n / 4;
      if (out_valid && first_valid < 0) first_valid = rel;
      if (done) begin done_cnt++; if (done_rel < 0) done_rel = rel; end
      if (done_rel >= 0 && rel == done_rel + 1) busy_after = int'(busy);
      prev_hold = out_valid && !out_ready;
      prev = {out_valid, el};
      if (out_valid && out_ready) begin g_el.push_back(el); hs_n++; end
      if (stop_after > 0 && hs_n == stop_after) break;
      if (done_rel >= 0 && rel == done_rel + 2) break;
      @(posedge clock); #1;
      start = (rel + 1 == restart_at);
      if (start) begin matrix_size = 5'd2; base_address = 10'h200; end
      out_ready = !stall || ((rel + 1) % 3 == 0);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({address, read, chipselect2, out_valid, out_data, out_row, out_col, out_diag, out_last, busy, done} !== 57'd0) begin
      n_fail++; $display("FAIL reset_held: outputs %h required 0", {address, read, chipselect2, out_valid, out_data, out_row, out_col, out_diag, out_last, busy, done});
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({address, read, chipselect2, out_valid, out_data, out_row, out_col, out_diag, out_last, busy, done} !== 57'd0) begin
      n_fail++; $display("FAIL reset_released: outputs %h required 0", {address, read, chipselect2, out_valid, out_data, out_row, out_col, out_diag, out_last, busy, done});
    end
    n_cmp++;
    if ({clken2, byteenable, write} !== {1'b1, 16'hFFFF, 1'b0}) begin
      n_fail++; $display("FAIL tie_offs: got %h required %h", {clken2, byteenable, write}, {1'b1, 16'hFFFF, 1'b0});
    end
  endtask

  task automatic test_basic;
    fill(10'h010, 4, 32'h0);
    run(4, 10'h010, 1'b0, 0, 0, 100);
    n_cmp++;
    if (g_el.size() !== 16) begin n_fail++; $display("FAIL basic_count: got %0d required 16", g_el.size()); end
    foreach (g_el[k]) begin
      n_cmp++;
      if (g_el[k] !== exp_el(k, 4, 32'h0)) begin
        n_fail++; $display("FAIL basic_elem[%0d]: got %h required %h", k, g_el[k], exp_el(k, 4, 32'h0));
      end
    end
    n_cmp++;
    if (g_addr.size() !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d required 4", g_addr.size()); end
    foreach (g_addr[k]) begin
      n_cmp++;
      if (g_addr[k] !== 10'h010 + 10'(k)) begin
        n_fail++; $display("FAIL basic_addr[%0d]: got %h required %h", k, g_addr[k], 10'h010 + 10'(k));
      end
    end
    n_cmp++;
    if (first_valid !== 3) begin n_fail++; $display("FAIL basic_first_valid: got %0d required 3", first_valid); end
    n_cmp++;
    if (done_rel !== 19) begin n_fail++; $display("FAIL basic_done_time: got %0d required 19", done_rel); end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); end
    n_cmp++;
    if (busy_after !== 0) begin n_fail++; $display("FAIL basic_busy_after_done: got %0d required 0", busy_after); end
  endtask

  task automatic test_wrap;
    int bad;
    fill(10'h3FE, 3, 32'h5000_0000);
    run(3, 10'h3FE, 1'b0, 0, 0, 100);
    n_cmp++;
    if (g_el.size() !== 9) begin n_fail++; $display("FAIL wrap_count: got %0d required 9", g_el.size()); end
    bad = count_bad(3, 32'h5000_0000);
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL wrap_elems: got %0d bad required 0", bad); end
    n_cmp++;
    if (g_addr.size() !== 3) begin n_fail++; $display("FAIL wrap_reads: got %0d required 3", g_addr.size()); end
    else begin
      n_cmp++;
      if ({g_addr[0], g_addr[1], g_addr[2]} !== {10'h3FE, 10'h3FF, 10'h000}) begin
        n_fail++; $display("FAIL wrap_addrs: got %h %h %h required 3fe 3ff 000", g_addr[0], g_addr[1], g_addr[2]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL wrap_done_pulses: got %0d required 1", done_cnt); end
  endtask

  task automatic test_stall;
    int bad;
    fill(10'h100, 64, 32'h1000_0000);
    run(16, 10'h100, 1'b1, 0, 0, 1200);
    n_cmp++;
    if (g_el.size() !== 256) begin n_fail++; $display("FAIL stall_count: got %0d required 256", g_el.size()); end
    bad = count_bad(16, 32'h1000_0000);
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_elems: got %0d bad required 0", bad); end
    n_cmp++;
    if (stall_err !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles required 0", stall_err); end
    n_cmp++;
    if (max_out > 2) begin n_fail++; $display("FAIL stall_outstanding: got %0d required <= 2", max_out); end
    n_cmp++;
    if (g_addr.size() !== 64) begin n_fail++; $display("FAIL stall_reads: got %0d required 64", g_addr.size()); end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done_pulses: got %0d required 1", done_cnt); end
  endtask

  task automatic test_zero;
    run(0, 10'h050, 1'b0, 0, 0, 20);
    n_cmp++;
    if (done_rel !== 1) begin n_fail++; $display("FAIL zero_done_time: got %0d required 1", done_rel); end
    n_cmp++;
    if (g_addr.size() !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d required 0", g_addr.size()); end
    n_cmp++;
    if (g_el.size() !== 0) begin n_fail++; $display("FAIL zero_elems: got %0d required 0", g_el.size()); end
    n_cmp++;
    if (busy_after !== 0) begin n_fail++; $display("FAIL zero_busy_after_done: got %0d required 0", busy_after); end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d required 1", done_cnt); end
  endtask

  task automatic test_restart;
    int bad;
    fill(10'h020, 4, 32'h2000_0000);
    run(4, 10'h020, 1'b0, 5, 0, 100);
    n_cmp++;
    if (g_el.size() !== 16) begin n_fail++; $display("FAIL restart_count: got %0d required 16", g_el.size()); end
    bad = count_bad(4, 32'h2000_0000);
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL restart_elems: got %0d bad required 0", bad); end
    n_cmp++;
    if (done_rel !== 19) begin n_fail++; $display("FAIL restart_done_time: got %0d required 19", done_rel); end
    n_cmp++;
    if (g_addr.size() !== 4) begin n_fail++; $display("FAIL restart_reads: got %0d required 4", g_addr.size()); end
  endtask

  task automatic test_reset_mid;
    int bad;
    fill(10'h300, 16, 32'h3000_0000);
    run(8, 10'h300, 1'b0, 0, 5, 100);
    n_cmp++;
    if (g_el.size() !== 5) begin n_fail++; $display("FAIL midrst_prefix: got %0d required 5", g_el.size()); end
    @(posedge clock); #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({address, read, chipselect2, out_valid, out_data, out_row, out_col, out_diag, out_last, busy, done} !== 57'd0) begin
      n_fail++; $display("FAIL midrst_async: outputs %h required 0", {address, read, chipselect2, out_valid, out_data, out_row, out_col, out_diag, out_last, busy, done});
    end
    @(posedge clock); #1 reset = 1'b0;
    fill(10'h040, 1, 32'h4000_0000);
    run(2, 10'h040, 1'b0, 0, 0, 50);
    n_cmp++;
    if (g_el.size() !== 4) begin n_fail++; $display("FAIL midrst_new_count: got %0d required 4", g_el.size()); end
    bad = count_bad(2, 32'h4000_0000);
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL midrst_new_elems: got %0d bad required 0", bad); end
    n_cmp++;
    if (done_rel !== 7) begin n_fail++; $display("FAIL midrst_new_done_time: got %0d required 7", done_rel); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_zero;
    test_restart;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
